chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request; accepted only while idle.
REQ-006 op_sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 cin  input  1  carry-in (add) / borrow-in (sub); sampled with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-013 cout  output  1  carry-out of the MSB chunk (raw adder carry, also in subtract mode).
REQ-014 ovf  output  1  signed two's-complement overflow of the full-width result.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: start=1 -> capture a, b_eff = op_sub ? ~b : b, carry = op_sub ? ~cin : cin, chunk index = 0, go RUN; start=0 -> stay.
REQ-017 Add computes a + b + cin; subtract computes a - b - cin (mod 2^WIDTH).
REQ-018 RUN: each cycle add chunk k of a, b_eff and carry; write chunk k of the result register; update carry; k increments by 1.
REQ-019 RUN with k = WIDTH/CHUNK-1 -> after that chunk go DONE; otherwise stay RUN.
REQ-020 DONE: done=1 for exactly one cycle; cout = final carry; ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb); next state IDLE.
REQ-021 Latency: start accepted at edge N -> done high in cycle N + WIDTH/CHUNK + 1; with defaults, 5 cycles after start.
REQ-022 busy = 1 in RUN and DONE, 0 in IDLE; a start may be accepted in the cycle after done.
REQ-023 start while busy SHALL be ignored without affecting operands, result or timing.
REQ-024 sum, cout, ovf SHALL change only at the DONE transition and SHALL hold otherwise, including while a new operation runs.
REQ-025 CHUNK == WIDTH SHALL be legal: single RUN cycle, latency 2.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the internal carry, index and operand registers.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the function computing the chunk count WIDTH/CHUNK.
REQ-029 A single combinational sub-module, chunk_adder (CHUNK-bit ripple of full-adder cells, inputs x, y, ci; outputs s, co), SHALL be instantiated once and reused across cycles.

Verification (WIDTH=16, CHUNK=4)
REQ-030 add: a=0x0003, b=0x0005, cin=0 -> done 5 cycles after start; sum=0x0008, cout=0, ovf=0.
REQ-031 wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-032 sub: op_sub=1, a=0x000A, b=0x0007, cin=1 -> sum=0x0002, cout=1; a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, ovf=1.
REQ-033 start pulsed every cycle during RUN with different operands -> first result unchanged; the next start is accepted only in the cycle after done.
REQ-034 rst asserted in the 2nd RUN cycle -> outputs 0 at once, no done pulse; a new add 0x1234+0x1111 -> sum=0x2345.
REQ-035 Random regression: 1000 random a, b, cin, op_sub compared with a reference model (sum, cout, ovf), done exactly once per start.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked (multi-cycle) adder.
// Holds the control FSM state encoding and chunk-count arithmetic.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register needs at least one bit even for a single chunk.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Request/result bundle of the chunked adder.
// master drives the request side, slave is the adder itself.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_adder_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
// Purely combinational; the top reuses one instance every cycle.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    always_comb begin : ripple
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock,
// LSB chunk first, carry held in a register between cycles.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst,
    chunked_adder_if.slave bus
);
    localparam int NCH = chunk_count(WIDTH, CHUNK);
    localparam int IW  = idx_bits(NCH);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("chunked_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nx;
    logic             carry_r;
    logic [IW-1:0]    idx_r;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] cx;
    logic [CHUNK-1:0] cy;
    logic [CHUNK-1:0] cs;
    logic             cco;
    logic             last;

    assign cx   = a_r[idx_r*CHUNK +: CHUNK];
    assign cy   = b_r[idx_r*CHUNK +: CHUNK];
    assign last = (idx_r == LAST);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (cx),
        .y  (cy),
        .ci (carry_r),
        .s  (cs),
        .co (cco)
    );

    always_comb begin
        res_nx = res_r;
        res_nx[idx_r*CHUNK +: CHUNK] = cs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Visible results update only on the RUN->DONE edge, so they
    // stay put while the next operation is being accumulated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.op_sub ? ~bus.b : bus.b;
                        carry_r <= bus.op_sub ^ bus.cin;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    res_r   <= res_nx;
                    carry_r <= cco;
                    idx_r   <= idx_r + 1'b1;
                    if (last) begin
                        sum_r  <= res_nx;
                        cout_r <= cco;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                  (res_nx[WIDTH-1] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed and random checks of chunked_adder (16/4), plus a
// single-chunk (16/16) instance for the one-cycle RUN case.
module tb_chunked_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus ();
    chunked_adder_if #(.WIDTH(16)) bus_w ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    assign bus_w.start  = bus.start;
    assign bus_w.op_sub = bus.op_sub;
    assign bus_w.a      = bus.a;
    assign bus_w.b      = bus.b;
    assign bus_w.cin    = bus.cin;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int n_ops = 0;
    logic [15:0] prev_sum = 16'h0;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic op, input logic [15:0] a, b,
                         input logic ci, output logic [15:0] s,
                         output logic co, output logic ov);
        logic [16:0] full;
        logic [15:0] be;
        be   = op ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'b0, op ^ ci};
        s    = full[15:0];
        co   = full[16];
        ov   = (a[15] == be[15]) && (s[15] != a[15]);
    endtask

    task automatic do_op(input string tag, input logic op,
                         input logic [15:0] a, b, input logic ci,
                         input logic [15:0] es, input logic ec,
                         input logic eo);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = op;
        bus.a = a; bus.b = b; bus.cin = ci;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 20) begin
            if (lat == 2) check({tag, ".hold"}, 32'(bus.sum), 32'(prev_sum));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".lat"}, lat, 5);
        check({tag, ".sum"}, 32'(bus.sum), 32'(es));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        n_ops++;
        prev_sum = es;
        @(negedge clk);
        check({tag, ".done_low"}, 32'(bus.done), 0);
        check({tag, ".idle"}, 32'(bus.busy), 0);
    endtask

    task automatic wide_op(input string tag, input logic op,
                           input logic [15:0] a, b, input logic ci,
                           input logic [15:0] es, input logic ec);
        int n;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op_sub = op;
        bus.a = a; bus.b = b; bus.cin = ci;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy"}, 32'(bus_w.busy), 1);
        check({tag, ".early"}, 32'(bus_w.done), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done"}, 32'(bus_w.done), 1);
        check({tag, ".sum"}, 32'(bus_w.sum), 32'(es));
        check({tag, ".cout"}, 32'(bus_w.cout), 32'(ec));
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".main_idle"}, 32'(bus.busy), 0);
        n_ops++;
        prev_sum = bus.sum;
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic rop, rci, ec, eo;
        int lat;
        int d0;

        rst = 1'b1;
        bus.start = 1'b0; bus.op_sub = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #1;
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.done", 32'(bus.done), 0);
        check("rst.sum", 32'(bus.sum), 0);
        check("rst.cout", 32'(bus.cout), 0);
        check("rst.ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("add", 1'b0, 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_op("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("povf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub", 1'b1, 16'h000A, 16'h0007, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op("novf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Abort in the second RUN cycle.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b0;
        bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(bus.busy), 0);
        check("abort.done", 32'(bus.done), 0);
        check("abort.sum", 32'(bus.sum), 0);
        check("abort.cout", 32'(bus.cout), 0);
        check("abort.ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort.no_done", done_cnt, d0);
        prev_sum = 16'h0;
        do_op("post_rst", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Start held high with changing operands while busy.
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b0;
        bus.a = 16'h0100; bus.b = 16'h0023; bus.cin = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!bus.done && lat < 20) begin
            bus.a = 16'h1000 + 16'(lat); bus.b = 16'h2000;
            bus.op_sub = lat[0]; bus.cin = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("busy.lat", lat, 5);
        check("busy.sum", 32'(bus.sum), 32'h0123);
        bus.a = 16'h0011; bus.b = 16'h0022;
        bus.op_sub = 1'b0; bus.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy.gap_idle", 32'(bus.busy), 0);
        check("busy.gap_sum", 32'(bus.sum), 32'h0123);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy.accept", 32'(bus.busy), 1);
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("busy.lat2", lat, 5);
        check("busy.sum2", 32'(bus.sum), 32'h0033);
        n_ops += 2;
        prev_sum = 16'h0033;

        wide_op("wide.add", 1'b0, 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0);
        wide_op("wide.sub", 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 1'($urandom);
            rci = 1'($urandom);
            model(rop, ra, rb, rci, es, ec, eo);
            do_op("rnd", rop, ra, rb, rci, es, ec, eo);
        end

        repeat (2) @(negedge clk);
        check("done_count", done_cnt, n_ops);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
